// File: rtl/aes_pkg.sv
// Shared helpers for the Rijndael ShiftRows datapath: legal block widths,
// per-row shift offsets and the byte layout of a packed state vector.
package aes_pkg;

   localparam int unsigned AES_ROWS = 4;

   // Rijndael defines ShiftRows only for 128/192/256-bit blocks.
   function automatic bit nb_legal(input int unsigned nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   // Row shift amount C_r; the 256-bit block uses 0,1,3,4.
   function automatic int unsigned row_off(input int unsigned nb, input int unsigned r);
      if ((nb == 8) && (r >= 2)) begin
         return r + 1;
      end
      return r;
   endfunction

   // LSB position of byte k (k = r + 4c); byte 0 is the most significant byte.
   function automatic int unsigned byte_lsb(input int unsigned nb, input int unsigned k);
      return 32 * nb - 8 * (k + 1);
   endfunction

endpackage

// File: rtl/aes_shift_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for one state.
module aes_shift_perm
   import aes_pkg::*;
#(
   parameter int unsigned NB = 4
) (
   input  logic [32*NB-1:0] in_state,
   input  logic             inv,
   output logic [32*NB-1:0] out_state
);

   if (!nb_legal(NB)) begin : g_bad_nb
      $error("aes_shift_perm: NB must be 4, 6 or 8");
   end

   // Each output byte (r,c) picks input column (c +/- C_r) mod NB of the same row.
   always_comb begin
      out_state = '0;
      for (int unsigned r = 0; r < AES_ROWS; r++) begin
         for (int unsigned c = 0; c < NB; c++) begin
            out_state[byte_lsb(NB, r + 4 * c) +: 8] =
               in_state[byte_lsb(NB, r + 4 * ((inv ? (c + NB - row_off(NB, r))
                                                   : (c + row_off(NB, r))) % NB)) +: 8];
         end
      end
   end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Elastic valid/ready pipeline around the ShiftRows permutation. The byte
// shuffle happens once in front of stage 0; later stages only move beats.
module aes_shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int unsigned NB          = 4,
   parameter int unsigned PIPE_STAGES = 1,
   parameter int unsigned TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_inv,
   input  logic [32*NB-1:0] in_state,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [32*NB-1:0] out_state,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned SW = 32 * NB;

   if (!nb_legal(NB)) begin : g_bad_nb
      $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if ((PIPE_STAGES < 1) || (PIPE_STAGES > 4)) begin : g_bad_stages
      $error("aes_shift_rows_pipe: PIPE_STAGES must be 1..4");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("aes_shift_rows_pipe: TAG_W must be at least 1");
   end

   logic [SW-1:0]          perm_state;
   logic [PIPE_STAGES-1:0] valid_vec;
   logic [PIPE_STAGES-1:0] load_vec;

   aes_shift_perm #(.NB(NB)) u_perm (
      .in_state  (in_state),
      .inv       (in_inv),
      .out_state (perm_state)
   );

   // Ready chain unrolled: a stage loads when out_ready is high or any stage
   // from itself to the output holds a bubble. Avoids a combinational
   // self-referencing vector while staying equivalent to !v[j] || load[j+1].
   always_comb begin
      load_vec = '0;
      for (int unsigned j = 0; j < PIPE_STAGES; j++) begin
         load_vec[j] = out_ready;
         for (int unsigned k = j; k < PIPE_STAGES; k++) begin
            if (!valid_vec[k]) begin
               load_vec[j] = 1'b1;
            end
         end
      end
   end

   // A flush discards any offered beat, so the input may look ready then.
   always_comb begin
      in_ready = load_vec[0] || clr;
   end

   for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
      logic             valid_q, valid_d;
      logic [SW-1:0]    state_q, state_d;
      logic [TAG_W-1:0] tag_q, tag_d;
      logic             up_valid;
      logic [SW-1:0]    up_state;
      logic [TAG_W-1:0] up_tag;

      if (g == 0) begin : g_src
         assign up_valid = in_valid;
         assign up_state = perm_state;
         assign up_tag   = in_tag;
      end else begin : g_src
         assign up_valid = g_stage[g-1].valid_q;
         assign up_state = g_stage[g-1].state_q;
         assign up_tag   = g_stage[g-1].tag_q;
      end

      assign valid_vec[g] = valid_q;

      // Take the upstream beat when loading; flush clears only the valid bit.
      always_comb begin
         valid_d = valid_q;
         state_d = state_q;
         tag_d   = tag_q;
         if (load_vec[g]) begin
            valid_d = up_valid;
            if (up_valid) begin
               state_d = up_state;
               tag_d   = up_tag;
            end
         end
         if (clr) begin
            valid_d = 1'b0;
         end
      end

      // Stage register with asynchronous clear of valid, data and tag.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            state_q <= '0;
            tag_q   <= '0;
         end else begin
            valid_q <= valid_d;
            state_q <= state_d;
            tag_q   <= tag_d;
         end
      end
   end

   assign out_valid = g_stage[PIPE_STAGES-1].valid_q;
   assign out_state = g_stage[PIPE_STAGES-1].state_q;
   assign out_tag   = g_stage[PIPE_STAGES-1].tag_q;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed and randomized checks of aes_shift_rows_pipe for NB = 4, 8 and 6.
module tb_aes_shift_rows_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // DUT A: NB=4, 1 stage
   logic clr_a, in_valid_a, in_ready_a, in_inv_a, out_valid_a, out_ready_a;
   logic [127:0] in_state_a, out_state_a;
   logic [3:0] in_tag_a, out_tag_a;
   // DUT B: NB=8, 2 stages
   logic clr_b, in_valid_b, in_ready_b, in_inv_b, out_valid_b, out_ready_b;
   logic [255:0] in_state_b, out_state_b;
   logic [3:0] in_tag_b, out_tag_b;
   // DUT C: NB=6, 3 stages
   logic clr_c, in_valid_c, in_ready_c, in_inv_c, out_valid_c, out_ready_c;
   logic [191:0] in_state_c, out_state_c;
   logic [3:0] in_tag_c, out_tag_c;

   aes_shift_rows_pipe #(.NB(4), .PIPE_STAGES(1), .TAG_W(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_inv(in_inv_a), .in_state(in_state_a), .in_tag(in_tag_a), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .out_state(out_state_a), .out_tag(out_tag_a));

   aes_shift_rows_pipe #(.NB(8), .PIPE_STAGES(2), .TAG_W(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_inv(in_inv_b), .in_state(in_state_b), .in_tag(in_tag_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .out_state(out_state_b), .out_tag(out_tag_b));

   aes_shift_rows_pipe #(.NB(6), .PIPE_STAGES(3), .TAG_W(4)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .clr(clr_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
      .in_inv(in_inv_c), .in_state(in_state_c), .in_tag(in_tag_c), .out_valid(out_valid_c),
      .out_ready(out_ready_c), .out_state(out_state_c), .out_tag(out_tag_c));

   // Reference: unpack into a byte grid, rotate each row by its table offset, repack.
   function automatic logic [255:0] ref_shift(input logic [255:0] s, input int nb, input bit inv);
      logic [7:0] b [32];
      logic [7:0] o [32];
      int offs [4];
      logic [255:0] res;
      int src;
      if (nb == 8) offs = '{0, 1, 3, 4};
      else         offs = '{0, 1, 2, 3};
      for (int k = 0; k < 4 * nb; k++) b[k] = s[32*nb-1-8*k -: 8];
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < nb; c++) begin
            src = inv ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
            o[r + 4*c] = b[r + 4*src];
         end
      end
      res = '0;
      for (int k = 0; k < 4 * nb; k++) res[32*nb-1-8*k -: 8] = o[k];
      return res;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [191:0] rand192();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Send one beat into DUT C (out_ready high) and check it exactly 3 cycles later.
   task automatic send_c(input string tag);
      logic [255:0] exp;
      logic [3:0]   etag;
      in_valid_c = 1'b1;
      in_state_c = rand192();
      in_inv_c   = 1'($urandom_range(0, 1));
      etag       = 4'($urandom_range(1, 15));
      in_tag_c   = etag;
      exp        = ref_shift({64'b0, in_state_c}, 6, in_inv_c);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         in_valid_c = 1'b0;
         if (k < 3) check({tag, "_early"}, {255'b0, out_valid_c}, 256'd0);
      end
      check({tag, "_valid"}, {255'b0, out_valid_c}, 256'd1);
      check({tag, "_state"}, {64'b0, out_state_c}, exp);
      check({tag, "_tag"}, {252'b0, out_tag_c}, {252'b0, etag});
   endtask

   logic [255:0] exp_a [8];
   logic [3:0]   etag_a [8];
   logic [255:0] q_state [$];
   logic [3:0]   q_tag [$];
   logic [63:0]  row2, row3;
   int sent, cyc;

   initial begin
      rst_n = 1'b0;
      {clr_a, in_valid_a, in_inv_a, in_state_a, in_tag_a} = '0;
      {clr_b, in_valid_b, in_inv_b, in_state_b, in_tag_b} = '0;
      {clr_c, in_valid_c, in_inv_c, in_state_c, in_tag_c} = '0;
      out_ready_a = 1'b1; out_ready_b = 1'b1; out_ready_c = 1'b1;

      // Reset state
      #12;
      check("rst_valid_a", {255'b0, out_valid_a}, 256'd0);
      check("rst_state_a", {128'b0, out_state_a}, 256'd0);
      check("rst_tag_a", {252'b0, out_tag_a}, 256'd0);
      check("rst_ready_a", {255'b0, in_ready_a}, 256'd1);
      check("rst_ready_c", {255'b0, in_ready_c}, 256'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("post_rst_ready_a", {255'b0, in_ready_a}, 256'd1);

      // NB=4 forward with known vector
      @(negedge clk);
      in_valid_a = 1'b1; in_inv_a = 1'b0; in_tag_a = 4'h5;
      in_state_a = 128'h000102030405060708090A0B0C0D0E0F;
      @(negedge clk);
      in_valid_a = 1'b0;
      check("fwd4_valid", {255'b0, out_valid_a}, 256'd1);
      check("fwd4_state", {128'b0, out_state_a}, {128'b0, 128'h00050A0F04090E03080D02070C01060B});
      check("fwd4_tag", {252'b0, out_tag_a}, 256'd5);

      // NB=4 inverse of the forward result
      in_valid_a = 1'b1; in_inv_a = 1'b1; in_tag_a = 4'h9;
      in_state_a = 128'h00050A0F04090E03080D02070C01060B;
      @(negedge clk);
      in_valid_a = 1'b0;
      check("inv4_state", {128'b0, out_state_a}, {128'b0, 128'h000102030405060708090A0B0C0D0E0F});
      check("inv4_tag", {252'b0, out_tag_a}, 256'd9);

      // NB=4 back-to-back alternating fwd/inv stream
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            check("alt4_valid", {255'b0, out_valid_a}, 256'd1);
            check("alt4_state", {128'b0, out_state_a}, exp_a[i-1]);
            check("alt4_tag", {252'b0, out_tag_a}, {252'b0, etag_a[i-1]});
         end
         if (i < 8) begin
            in_valid_a = 1'b1;
            in_inv_a   = 1'(i % 2);
            in_state_a = {$urandom, $urandom, $urandom, $urandom};
            in_tag_a   = 4'(i);
            exp_a[i]   = ref_shift({128'b0, in_state_a}, 4, in_inv_a);
            etag_a[i]  = 4'(i);
         end else begin
            in_valid_a = 1'b0;
         end
         @(negedge clk);
      end

      // NB=8 forward, bytes 00..1F, two-stage latency
      for (int k = 0; k < 32; k++) in_state_b[255-8*k -: 8] = 8'(k);
      in_valid_b = 1'b1; in_inv_b = 1'b0; in_tag_b = 4'h3;
      @(negedge clk);
      in_valid_b = 1'b0;
      check("fwd8_early", {255'b0, out_valid_b}, 256'd0);
      @(negedge clk);
      check("fwd8_valid", {255'b0, out_valid_b}, 256'd1);
      for (int c = 0; c < 8; c++) begin
         row2[63-8*c -: 8] = out_state_b[255-8*(2+4*c) -: 8];
         row3[63-8*c -: 8] = out_state_b[255-8*(3+4*c) -: 8];
      end
      check("fwd8_row2", {192'b0, row2}, {192'b0, 64'h0E12161A1E02060A});
      check("fwd8_row3", {192'b0, row3}, {192'b0, 64'h13171B1F03070B0F});
      check("fwd8_model", out_state_b, ref_shift(in_state_b, 8, 1'b0));
      check("fwd8_tag", {252'b0, out_tag_b}, 256'd3);

      // NB=6, 3 stages: 50 random beats with random backpressure
      sent = 0; cyc = 0;
      while ((sent < 50 || q_state.size() > 0) && cyc < 2000) begin
         out_ready_c = ($urandom_range(0, 9) < 6);
         in_valid_c  = (sent < 50) && ($urandom_range(0, 3) != 0);
         in_state_c  = rand192();
         in_inv_c    = 1'($urandom_range(0, 1));
         in_tag_c    = 4'($urandom_range(0, 15));
         #1;
         check("rdy6", {255'b0, in_ready_c},
               {255'b0, !(q_state.size() == 3 && !out_ready_c)});
         if (out_valid_c && out_ready_c) begin
            if (q_state.size() == 0) begin
               check("extra6", 256'd1, 256'd0);
            end else begin
               check("rand6_state", {64'b0, out_state_c}, q_state.pop_front());
               check("rand6_tag", {252'b0, out_tag_c}, {252'b0, q_tag.pop_front()});
            end
         end
         if (in_valid_c && in_ready_c) begin
            q_state.push_back(ref_shift({64'b0, in_state_c}, 6, in_inv_c));
            q_tag.push_back(in_tag_c);
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      check("drain6_sent", 256'(sent), 256'd50);
      check("drain6_left", 256'(q_state.size()), 256'd0);
      in_valid_c = 1'b0;

      // Flush with 3 beats in flight and a beat offered in the same cycle
      out_ready_c = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid_c = 1'b1; in_state_c = rand192(); in_tag_c = 4'(k + 1);
         @(negedge clk);
      end
      in_valid_c = 1'b0;
      #1;
      check("full6_ready", {255'b0, in_ready_c}, 256'd0);
      check("full6_valid", {255'b0, out_valid_c}, 256'd1);
      clr_c = 1'b1; in_valid_c = 1'b1; in_state_c = rand192(); in_tag_c = 4'hE;
      @(negedge clk);
      clr_c = 1'b0; in_valid_c = 1'b0;
      #1;
      check("flush6_valid", {255'b0, out_valid_c}, 256'd0);
      check("flush6_ready", {255'b0, in_ready_c}, 256'd1);
      out_ready_c = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("stale6", {255'b0, out_valid_c}, 256'd0);
      end
      send_c("post_flush6");

      // Asynchronous reset mid-burst
      out_ready_c = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid_c = 1'b1; in_state_c = rand192() | 192'h1; in_tag_c = 4'hA;
         @(negedge clk);
      end
      in_valid_c = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst6_valid", {255'b0, out_valid_c}, 256'd0);
      check("arst6_state", {64'b0, out_state_c}, 256'd0);
      check("arst6_tag", {252'b0, out_tag_c}, 256'd0);
      check("arst6_ready", {255'b0, in_ready_c}, 256'd1);
      check("arst4_state", {128'b0, out_state_a}, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready_c = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("arst6_idle", {255'b0, out_valid_c}, 256'd0);
      end
      send_c("post_rst6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
